// File: rtl/irq_bus_sequencer.sv
// irq_bus_sequencer: edge-captured interrupts, each serviced by a timer-reload write then a counter-display write
module irq_bus_sequencer #(
    parameter int          N_CH      = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] TMR_ADDR  = 32'hF000_0004,
    parameter logic [31:0] TMR_VAL   = 32'hF800_0000,
    parameter logic [31:0] DISP_BASE = 32'hE000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] int_in,
    input  logic            mio_ready,
    output logic            mem_w,
    output logic [31:0]     addr_out,
    output logic [31:0]     data_out,
    output logic [2:0]      dmtype,
    output logic            busy,
    output logic [N_CH-1:0] overflow
);
    localparam int GW = N_CH > 1 ? $clog2(N_CH) : 1;
    typedef enum logic [1:0] {IDLE, WR_TMR, WR_DISP} state_t;
    state_t state, state_nx;
    logic [N_CH-1:0] int_prev, pending, edge_det, clr;
    logic [CNT_W-1:0] cnt [N_CH];
    logic [GW-1:0] g, g_sel;
    logic grant;
    assign edge_det = int_in & ~int_prev;
    assign grant = state == IDLE && |pending;
    assign clr = grant ? N_CH'(1) << g_sel : '0;
    assign dmtype = 3'b000;
    always_comb begin
        g_sel = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (pending[i]) g_sel = GW'(i);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? WR_TMR : IDLE;
            WR_TMR:  state_nx = mio_ready ? WR_DISP : WR_TMR;
            WR_DISP: state_nx = mio_ready ? IDLE : WR_DISP;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        mem_w = state != IDLE;
        busy = state != IDLE;
        addr_out = state == WR_TMR ? TMR_ADDR : state == WR_DISP ? DISP_BASE + (32'(g) << 2) : DISP_BASE;
        data_out = state == WR_TMR ? TMR_VAL : state == WR_DISP ? 32'(cnt[g]) : 32'd0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            int_prev <= '0;
            pending <= '0;
            overflow <= '0;
            g <= '0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            int_prev <= int_in;
            pending <= (pending & ~clr) | edge_det;
            overflow <= overflow | (edge_det & pending & ~clr);
            if (grant) begin
                g <= g_sel;
                cnt[g_sel] <= cnt[g_sel] + CNT_W'(1);
            end
        end
endmodule

// File: doc/irq_bus_sequencer.md
IRQ_BUS_SEQUENCER -- requirements
Module: irq_bus_sequencer

Interface
REQ-001 Parameter N_CH, default 4: number of interrupt channels, 1..16.
REQ-002 Parameter CNT_W, default 32: per-channel event counter width, 1..32.
REQ-003 Parameter TMR_ADDR, default 32'hF000_0004: timer reload register address.
REQ-004 Parameter TMR_VAL, default 32'hF800_0000: timer reload data word.
REQ-005 Parameter DISP_BASE, default 32'hE000_0000: display base address; channel c writes DISP_BASE + 4*c.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 int_in  in  N_CH  interrupt request lines; level-sampled, rising-edge significant.
REQ-009 mio_ready  in  1  bus accepts the current write when high at a rising clk edge.
REQ-010 mem_w  out  1  bus write strobe.
REQ-011 addr_out  out  32  bus write address.
REQ-012 data_out  out  32  bus write data.
REQ-013 dmtype  out  3  access type; constant word encoding 3'b000.
REQ-014 busy  out  1  high whenever FSM is not IDLE.
REQ-015 overflow  out  N_CH  sticky per-channel lost-event flag.

Function
REQ-016 Edge detect: per channel, int_prev register; edge[c] = int_in[c] & ~int_prev[c]; int_prev updated every cycle.
REQ-017 On edge[c], pending[c] SHALL set at that clock edge.
REQ-018 If edge[c] occurs while pending[c] already set and not being cleared that cycle, overflow[c] SHALL set; event is dropped, counter unaffected.
REQ-019 If edge[c] coincides with pending[c] being cleared by grant, pending[c] SHALL remain set; overflow[c] unchanged.
REQ-020 FSM states: IDLE, WR_TMR, WR_DISP.
REQ-021 IDLE: if any pending bit set, grant lowest-index pending channel g; clear pending[g]; cnt[g] <= cnt[g]+1 modulo 2^CNT_W (all-ones wraps to 0); latch g; go to WR_TMR.
REQ-022 WR_TMR: mem_w=1, addr_out=TMR_ADDR, data_out=TMR_VAL; stay until mio_ready=1 at a clock edge, then go to WR_DISP.
REQ-023 WR_DISP: mem_w=1, addr_out=DISP_BASE+4*g, data_out=cnt[g] zero-extended to 32 bits; stay until mio_ready=1, then go to IDLE.
REQ-024 IDLE outputs: mem_w=0, addr_out=DISP_BASE, data_out=0.
REQ-025 Latency: pending set at edge E0 with FSM in IDLE -> transition at E1 -> mem_w high from E1; with mio_ready held high, the two writes occupy exactly 2 cycles and FSM returns to IDLE at E3.
REQ-026 Outputs SHALL be a function of registered state only; no combinational path from mio_ready or int_in to outputs.
REQ-027 Edges arriving while busy SHALL be captured in pending and serviced after return to IDLE, in priority order.

Reset
REQ-028 rst high SHALL immediately force IDLE, mem_w=0, addr_out=DISP_BASE, data_out=0, busy=0, and clear pending, overflow, all counters, int_prev and latched grant.
REQ-029 Reset mid-write SHALL abandon the transaction; the granted channel's increment stands only until reset clears the counters.
REQ-030 After deassertion, an int_in line already high SHALL register one edge on the first clock.

Verification
REQ-031 Single pulse on int_in[0], mio_ready=1 -> write (F000_0004, F800_0000), then (E000_0000, 1); busy low at E3.
REQ-032 int_in[2] and int_in[1] rise same cycle -> ch1 serviced first (E000_0004, 1), then ch2 (E000_0008, 1); overflow=0.
REQ-033 mio_ready low 3 cycles in WR_TMR -> address/data held stable 4 cycles, single write accepted, then WR_DISP.
REQ-034 Three edges on ch0 while busy stalled (mio_ready=0) -> one extra service; overflow[0]=1; final display data 2.
REQ-035 CNT_W=2, five ch3 events -> display data sequence 1,2,3,0,1.
REQ-036 rst asserted during WR_DISP -> mem_w drops immediately; next ch0 event displays 1.
